// File: rtl/odesa_layer_wta.sv
// Event-driven spiking layer: decaying synapse traces, dot-product neuron levels, registered winner-take-all.
// Latency: event at edge t -> trace at t+1, level at t+2, spike at t+3.
// No backpressure: events are always accepted; evaluations landing in the refractory window are dropped.
module odesa_layer_wta #(
    parameter int P_WIDTH     = 9,
    parameter int P_SYN       = 8,
    parameter int P_NEURONS   = 2,
    parameter int P_DECAY_DIV = 16,
    parameter int P_REFRACT   = 4
) (
    input  logic                                                 i_clk,
    input  logic                                                 i_rst,
    input  logic [P_SYN-1:0]                                     i_event,
    input  logic [P_NEURONS*P_SYN*P_WIDTH-1:0]                   i_weight,
    input  logic [P_NEURONS*(2*P_WIDTH+$clog2(P_SYN))-1:0]       i_threshold,
    output logic [P_SYN*P_WIDTH-1:0]                             o_tr,
    output logic [P_NEURONS*(2*P_WIDTH+$clog2(P_SYN))-1:0]       o_lv,
    output logic [P_NEURONS-1:0]                                 o_spike,
    output logic [$clog2(P_NEURONS)-1:0]                         o_winner,
    output logic                                                 o_refract
);

    localparam int LVW = 2*P_WIDTH + $clog2(P_SYN);
    localparam int IW  = $clog2(P_NEURONS);
    localparam int PW  = $clog2(P_DECAY_DIV + 1);
    localparam int RW  = $clog2(P_REFRACT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EVAL    = 2'd1,
        S_FIRE    = 2'd2,
        S_REFRACT = 2'd3
    } state_t;

    logic [PW-1:0]      r_pre;
    logic               w_wrap;
    logic [P_WIDTH-1:0] r_tr [P_SYN];
    logic [LVW-1:0]     r_lv [P_NEURONS];
    logic [LVW-1:0]     w_lv_nxt [P_NEURONS];
    logic               r_eval1;
    state_t             r_state;
    logic [RW-1:0]      r_cnt;

    logic                 w_found;
    logic [IW-1:0]        w_best_idx;
    logic [LVW-1:0]       w_best_lv;
    logic [P_NEURONS-1:0] w_onehot;

    assign w_wrap = (r_pre == PW'(P_DECAY_DIV - 1));

    // Decay prescaler: free-running 0..P_DECAY_DIV-1, one decay step per wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pre <= '0;
        end else if (w_wrap) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // Traces: an event reloads full scale and takes priority over a decay step in the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < P_SYN; s++) begin
                r_tr[s] <= '0;
            end
        end else begin
            for (int s = 0; s < P_SYN; s++) begin
                if (i_event[s]) begin
                    r_tr[s] <= '1;
                end else if (w_wrap && (r_tr[s] != '0)) begin
                    r_tr[s] <= r_tr[s] - P_WIDTH'(1);
                end
            end
        end
    end

    // Flatten traces onto the output bus.
    always_comb begin
        o_tr = '0;
        for (int s = 0; s < P_SYN; s++) begin
            o_tr[s*P_WIDTH +: P_WIDTH] = r_tr[s];
        end
    end

    // Next level per neuron: weight/trace dot product, LVW is wide enough that it cannot overflow.
    always_comb begin
        for (int n = 0; n < P_NEURONS; n++) begin
            w_lv_nxt[n] = '0;
            for (int s = 0; s < P_SYN; s++) begin
                w_lv_nxt[n] = w_lv_nxt[n]
                            + LVW'(i_weight[(n*P_SYN+s)*P_WIDTH +: P_WIDTH]) * LVW'(r_tr[s]);
            end
        end
    end

    // Register levels every cycle, independent of evaluation or refractory state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int n = 0; n < P_NEURONS; n++) begin
                r_lv[n] <= '0;
            end
        end else begin
            for (int n = 0; n < P_NEURONS; n++) begin
                r_lv[n] <= w_lv_nxt[n];
            end
        end
    end

    // Flatten registered levels onto the output bus.
    always_comb begin
        o_lv = '0;
        for (int n = 0; n < P_NEURONS; n++) begin
            o_lv[n*LVW +: LVW] = r_lv[n];
        end
    end

    // Winner search over registered levels; strict '>' keeps the lowest index on ties.
    always_comb begin
        w_found    = 1'b0;
        w_best_idx = '0;
        w_best_lv  = '0;
        for (int n = 0; n < P_NEURONS; n++) begin
            if ((r_lv[n] >= i_threshold[n*LVW +: LVW]) && (!w_found || (r_lv[n] > w_best_lv))) begin
                w_found    = 1'b1;
                w_best_lv  = r_lv[n];
                w_best_idx = IW'(n);
            end
        end
    end

    // One-hot decode of the winning index.
    always_comb begin
        w_onehot = '0;
        for (int n = 0; n < P_NEURONS; n++) begin
            w_onehot[n] = (IW'(n) == w_best_idx);
        end
    end

    // Eval pipeline and WTA FSM; S_EVAL is the eval2 cycle, FIRE and REFRACT both swallow evaluations.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_eval1   <= 1'b0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            o_spike   <= '0;
            o_winner  <= '0;
            o_refract <= 1'b0;
        end else begin
            r_eval1 <= |i_event;
            o_spike <= '0;
            case (r_state)
                S_IDLE: begin
                    if (r_eval1) begin
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (w_found) begin
                        o_spike  <= w_onehot;
                        o_winner <= w_best_idx;
                        r_cnt    <= RW'(P_REFRACT);
                        r_state  <= S_FIRE;
                    end else if (r_eval1) begin
                        r_state <= S_EVAL;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FIRE: begin
                    o_refract <= 1'b1;
                    r_state   <= S_REFRACT;
                end
                S_REFRACT: begin
                    if (r_cnt == RW'(1)) begin
                        o_refract <= 1'b0;
                        r_cnt     <= '0;
                        // An eval1 in the last refractory cycle lands its eval2 just after the window.
                        r_state   <= r_eval1 ? S_EVAL : S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - RW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_odesa_layer_wta.sv
module tb_odesa_layer_wta;

    localparam int W   = 4;
    localparam int S   = 4;
    localparam int N   = 3;
    localparam int LVW = 2*W + 2;
    localparam int IW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [S-1:0]       ev;
    logic [N*S*W-1:0]   weight;
    logic [N*LVW-1:0]   thr;
    logic [S*W-1:0]     tr;
    logic [N*LVW-1:0]   lv;
    logic [N-1:0]       spike;
    logic [IW-1:0]      winner;
    logic               refract;

    int checks = 0;
    int errors = 0;
    int spike_cnt = 0;
    int multihot = 0;
    int base;

    always #5 clk = ~clk;

    odesa_layer_wta #(
        .P_WIDTH(W), .P_SYN(S), .P_NEURONS(N), .P_DECAY_DIV(4), .P_REFRACT(3)
    ) u_dut (
        .i_clk(clk), .i_rst(rst), .i_event(ev), .i_weight(weight), .i_threshold(thr),
        .o_tr(tr), .o_lv(lv), .o_spike(spike), .o_winner(winner), .o_refract(refract)
    );

    // Spike monitor on the falling edge: total spikes and any multi-hot pulse.
    always @(negedge clk) begin
        if (spike != '0) begin
            spike_cnt++;
            if ($countones(spike) > 1) multihot++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    task automatic set_w(input int n, input int s, input logic [W-1:0] v);
        weight[(n*S+s)*W +: W] = v;
    endtask

    task automatic set_thr(input int n, input logic [LVW-1:0] v);
        thr[n*LVW +: LVW] = v;
    endtask

    function automatic logic [LVW-1:0] lv_of(input int n);
        return lv[n*LVW +: LVW];
    endfunction

    task automatic pulse_event(input logic [S-1:0] v);
        ev = v;
        tick(1);
        ev = '0;
    endtask

    initial begin
        rst = 1'b1;
        ev = '0;
        weight = '0;
        thr = '0;
        tick(2);
        rst = 1'b0;
        base = spike_cnt;

        // Idle after reset: everything quiet.
        tick(20);
        chk("idle_tr", 64'(tr), 64'h0);
        chk("idle_lv", 64'(lv), 64'h0);
        chk("idle_spike", 64'(spike), 64'h0);
        chk("idle_winner", 64'(winner), 64'h0);
        chk("idle_refract", 64'(refract), 64'h0);
        chk("idle_nospike", 64'(spike_cnt - base), 64'h0);

        // Basic fire: weights {1,2,3} on synapse 0, thresholds 10 -> neuron 2 wins.
        set_w(0, 0, 4'd1);
        set_w(1, 0, 4'd2);
        set_w(2, 0, 4'd3);
        for (int n = 0; n < N; n++) set_thr(n, 10'd10);
        base = spike_cnt;
        pulse_event(4'b0001);                    // edge A
        chk("t1_tr0", 64'(tr[3:0]), 64'd15);
        tick(1);                                 // A+1
        chk("t2_lv0", 64'(lv_of(0)), 64'd15);
        chk("t2_lv1", 64'(lv_of(1)), 64'd30);
        chk("t2_lv2", 64'(lv_of(2)), 64'd45);
        chk("t2_nospike", 64'(spike), 64'h0);
        tick(1);                                 // A+2
        chk("t3_spike", 64'(spike), 64'b100);
        chk("t3_winner", 64'(winner), 64'd2);
        chk("t3_refract", 64'(refract), 64'd0);
        tick(1);                                 // A+3
        chk("t4_spike", 64'(spike), 64'h0);
        chk("t4_refract", 64'(refract), 64'd1);
        chk("decay_first", 64'(tr[3:0]), 64'd14);
        tick(1);                                 // A+4
        chk("decay_lv2", 64'(lv_of(2)), 64'd42);
        tick(2);                                 // A+6
        chk("t7_refract", 64'(refract), 64'd0);
        chk("decay_hold", 64'(tr[3:0]), 64'd14);
        tick(1);                                 // A+7
        chk("decay_second", 64'(tr[3:0]), 64'd13);
        tick(51);                                // A+58
        chk("decay_one", 64'(tr[3:0]), 64'd1);
        tick(1);                                 // A+59
        chk("decay_zero", 64'(tr[3:0]), 64'd0);
        tick(20);
        chk("decay_nowrap", 64'(tr[3:0]), 64'd0);
        chk("decay_lv_zero", 64'(lv), 64'h0);
        chk("basic_spike_count", 64'(spike_cnt - base), 64'd1);

        // Tie between neurons 0 and 1 -> lowest index.
        do_reset();
        set_w(0, 0, 4'd2);
        set_w(1, 0, 4'd2);
        set_w(2, 0, 4'd0);
        for (int n = 0; n < N; n++) set_thr(n, 10'd1);
        pulse_event(4'b0001);
        tick(1);
        chk("tie_lv0", 64'(lv_of(0)), 64'd30);
        chk("tie_lv1", 64'(lv_of(1)), 64'd30);
        tick(1);
        chk("tie_spike", 64'(spike), 64'b001);
        chk("tie_winner", 64'(winner), 64'd0);
        tick(6);

        // Raise neuron 0 threshold above its level -> neuron 1 wins.
        set_thr(0, 10'd40);
        do_reset();
        pulse_event(4'b0001);
        tick(2);
        chk("thr_spike", 64'(spike), 64'b010);
        chk("thr_winner", 64'(winner), 64'd1);
        tick(6);

        // Events on consecutive cycles: second evaluation lands in the spike cycle and is dropped.
        do_reset();
        set_w(0, 0, 4'd1);
        set_w(1, 0, 4'd2);
        set_w(2, 0, 4'd3);
        for (int n = 0; n < N; n++) set_thr(n, 10'd10);
        base = spike_cnt;
        ev = 4'b0001;
        tick(1);                                 // A
        tick(1);                                 // A+1
        ev = '0;
        tick(1);                                 // A+2
        chk("dbl_spike", 64'(spike), 64'b100);
        tick(1);                                 // A+3
        chk("dbl_nospike_a", 64'(spike), 64'h0);
        chk("dbl_refract_a", 64'(refract), 64'd1);
        tick(1);
        chk("dbl_refract_b", 64'(refract), 64'd1);
        tick(1);
        chk("dbl_refract_c", 64'(refract), 64'd1);
        tick(1);                                 // A+6
        chk("dbl_refract_end", 64'(refract), 64'd0);
        tick(4);
        chk("dbl_spike_count", 64'(spike_cnt - base), 64'd1);

        // Reset two edges after an event aborts the pending evaluation.
        do_reset();
        base = spike_cnt;
        pulse_event(4'b0001);                    // A
        tick(1);                                 // A+1
        rst = 1'b1;
        tick(1);                                 // A+2 (reset edge)
        rst = 1'b0;
        chk("rst_spike", 64'(spike), 64'h0);
        chk("rst_tr", 64'(tr), 64'h0);
        chk("rst_lv", 64'(lv), 64'h0);
        tick(10);
        chk("rst_spike_count", 64'(spike_cnt - base), 64'd0);

        // Event on the decay-wrap edge reloads full scale.
        do_reset();
        tick(3);
        pulse_event(4'b1001);                    // 4th edge after reset: prescaler wraps
        chk("wrap_tr", 64'(tr), 64'hF00F);
        tick(3);
        chk("wrap_hold", 64'(tr[3:0]), 64'd15);
        tick(1);
        chk("wrap_next_decay", 64'(tr[3:0]), 64'd14);
        tick(8);

        chk("never_multihot", 64'(multihot), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
